// File: rtl/lpad_tracker.sv
// lpad_tracker: Zicfilp expected-landing-pad state (ELP/LPL) and banked MPELP/SPELP bits.
// Ports: clk_i/rst_i (async active-high); lpe_i enforcement enable; commit_valid_i,
// commit_ijump_i, commit_lpad_i, commit_label_i per commit port; ex_valid_i/trap_to_m_i
// trap entry; mret_i/sret_i returns; elp_o, lpl_o, mpelp_o, spelp_o registered state.
package config_pkg;
    typedef struct packed {
        int unsigned NrCommitPorts;
    } cva6_cfg_t;
    localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};
endpackage

module lpad_tracker #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    localparam int unsigned NCP = CVA6Cfg.NrCommitPorts
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lpe_i,
    input  logic [NCP-1:0]        commit_valid_i,
    input  logic [NCP-1:0]        commit_ijump_i,
    input  logic [NCP-1:0]        commit_lpad_i,
    input  logic [NCP-1:0][19:0]  commit_label_i,
    input  logic                  ex_valid_i,
    input  logic                  trap_to_m_i,
    input  logic                  mret_i,
    input  logic                  sret_i,
    output logic                  elp_o,
    output logic [19:0]           lpl_o,
    output logic                  mpelp_o,
    output logic                  spelp_o
);
    logic        elp_q, elp_c, elp_d;
    logic [19:0] lpl_q, lpl_c, lpl_d;
    logic        mpelp_q, mpelp_d;
    logic        spelp_q, spelp_d;
    // Later ports see the effect of earlier ports, so the last matching port wins.
    always_comb begin
        elp_c = elp_q;
        lpl_c = lpl_q;
        for (int unsigned i = 0; i < NCP; i++) begin
            if (commit_valid_i[i] && commit_ijump_i[i] && lpe_i) begin
                elp_c = 1'b1;
                lpl_c = commit_label_i[i];
            end else if (commit_valid_i[i] && commit_lpad_i[i]) begin
                elp_c = 1'b0;
            end
        end
    end
    // A trap discards the commit chain and saves the registered ELP; returns override commits.
    always_comb begin
        elp_d   = ex_valid_i ? 1'b0 : mret_i ? mpelp_q : sret_i ? spelp_q : elp_c;
        lpl_d   = ex_valid_i ? lpl_q : lpl_c;
        mpelp_d = ex_valid_i ? (trap_to_m_i ? elp_q : mpelp_q) : (mret_i ? 1'b0 : mpelp_q);
        spelp_d = ex_valid_i ? (trap_to_m_i ? spelp_q : elp_q) : (sret_i ? 1'b0 : spelp_q);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            elp_q   <= 1'b0;
            lpl_q   <= '0;
            mpelp_q <= 1'b0;
            spelp_q <= 1'b0;
        end else begin
            elp_q   <= elp_d;
            lpl_q   <= lpl_d;
            mpelp_q <= mpelp_d;
            spelp_q <= spelp_d;
        end
    end
    assign elp_o   = elp_q;
    assign lpl_o   = lpl_q;
    assign mpelp_o = mpelp_q;
    assign spelp_o = spelp_q;
    a_no_ijump_and_lpad: assert property (@(posedge clk_i) disable iff (rst_i)
        (commit_valid_i & commit_ijump_i & commit_lpad_i) == '0);
    a_no_mret_and_sret: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mret_i && sret_i));
endmodule

// File: tb/tb_lpad_tracker.sv
// tb_lpad_tracker: directed and randomized checks of lpad_tracker against a rule-level model.
module tb_lpad_tracker;
    localparam int NCP = 2;
    logic                 clk_i = 0;
    logic                 rst_i = 1;
    logic                 lpe_i;
    logic [NCP-1:0]       commit_valid_i, commit_ijump_i, commit_lpad_i;
    logic [NCP-1:0][19:0] commit_label_i;
    logic                 ex_valid_i, trap_to_m_i, mret_i, sret_i;
    logic                 elp_o, mpelp_o, spelp_o;
    logic [19:0]          lpl_o;
    int tests = 0;
    int fails = 0;
    bit        m_elp, m_mpelp, m_spelp;
    bit [19:0] m_lpl;

    lpad_tracker dut (
        .clk_i(clk_i), .rst_i(rst_i), .lpe_i(lpe_i),
        .commit_valid_i(commit_valid_i), .commit_ijump_i(commit_ijump_i),
        .commit_lpad_i(commit_lpad_i), .commit_label_i(commit_label_i),
        .ex_valid_i(ex_valid_i), .trap_to_m_i(trap_to_m_i),
        .mret_i(mret_i), .sret_i(sret_i),
        .elp_o(elp_o), .lpl_o(lpl_o), .mpelp_o(mpelp_o), .spelp_o(spelp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        lpe_i = 1; commit_valid_i = '0; commit_ijump_i = '0; commit_lpad_i = '0;
        commit_label_i = '0; ex_valid_i = 0; trap_to_m_i = 0; mret_i = 0; sret_i = 0;
    endtask

    // Apply the architectural rules to the current inputs, then advance one clock.
    task automatic tick();
        bit        e;
        bit [19:0] l;
        e = m_elp; l = m_lpl;
        if (ex_valid_i) begin
            if (trap_to_m_i) m_mpelp = m_elp; else m_spelp = m_elp;
            m_elp = 0;
        end else begin
            for (int i = 0; i < NCP; i++)
                if (commit_valid_i[i]) begin
                    if (commit_ijump_i[i] && lpe_i) begin e = 1; l = commit_label_i[i]; end
                    else if (commit_lpad_i[i]) e = 0;
                end
            m_lpl = l;
            if (mret_i) begin e = m_mpelp; m_mpelp = 0; end
            else if (sret_i) begin e = m_spelp; m_spelp = 0; end
            m_elp = e;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic ijump0(input logic [19:0] lbl);
        idle(); commit_valid_i[0] = 1; commit_ijump_i[0] = 1; commit_label_i[0] = lbl; tick();
    endtask

    task automatic test_reset();
        idle(); rst_i = 1;
        m_elp = 0; m_lpl = 0; m_mpelp = 0; m_spelp = 0;
        repeat (2) @(posedge clk_i);
        #1; rst_i = 0; tick();
        tests++; if ({elp_o, lpl_o, mpelp_o, spelp_o} !== 23'd0) begin
            fails++; $display("FAIL reset_init: got %b_%h_%b_%b want all 0", elp_o, lpl_o, mpelp_o, spelp_o); end
        ijump0(20'h5A5A5);
        idle(); ex_valid_i = 1; trap_to_m_i = 1; tick();
        ijump0(20'h0F0F0);
        tests++; if ({elp_o, mpelp_o} !== 2'b11) begin
            fails++; $display("FAIL reset_setup: got elp=%b mpelp=%b want 1 1", elp_o, mpelp_o); end
        idle(); #2; rst_i = 1; #1;
        m_elp = 0; m_lpl = 0; m_mpelp = 0; m_spelp = 0;
        tests++; if ({elp_o, lpl_o, mpelp_o, spelp_o} !== 23'd0) begin
            fails++; $display("FAIL reset_async: got %b_%h_%b_%b want all 0", elp_o, lpl_o, mpelp_o, spelp_o); end
        commit_valid_i[0] = 1; commit_ijump_i[0] = 1; commit_label_i[0] = 20'hFFFFF;
        @(posedge clk_i); #1;
        tests++; if ({elp_o, lpl_o} !== 21'd0) begin
            fails++; $display("FAIL reset_hold: got elp=%b lpl=%h want 0 0", elp_o, lpl_o); end
        idle(); rst_i = 0; tick();
        tests++; if ({elp_o, lpl_o, mpelp_o, spelp_o} !== 23'd0) begin
            fails++; $display("FAIL reset_release: got %b_%h_%b_%b want all 0", elp_o, lpl_o, mpelp_o, spelp_o); end
    endtask

    task automatic test_ijump_lpad();
        ijump0(20'hABCDE);
        tests++; if ({elp_o, lpl_o} !== {1'b1, 20'hABCDE}) begin
            fails++; $display("FAIL ijump_arm: got elp=%b lpl=%h want 1 abcde", elp_o, lpl_o); end
        idle(); commit_valid_i[0] = 1; commit_lpad_i[0] = 1; tick();
        tests++; if ({elp_o, lpl_o} !== {1'b0, 20'hABCDE}) begin
            fails++; $display("FAIL lpad_disarm: got elp=%b lpl=%h want 0 abcde", elp_o, lpl_o); end
    endtask

    task automatic test_ordering();
        idle(); commit_valid_i = 2'b11; commit_ijump_i = 2'b01; commit_lpad_i = 2'b10;
        commit_label_i[0] = 20'h00011; tick();
        tests++; if ({elp_o, lpl_o} !== {1'b0, 20'h00011}) begin
            fails++; $display("FAIL order_ijump_lpad: got elp=%b lpl=%h want 0 00011", elp_o, lpl_o); end
        idle(); commit_valid_i = 2'b11; commit_ijump_i = 2'b10; commit_lpad_i = 2'b01;
        commit_label_i[1] = 20'h00022; tick();
        tests++; if ({elp_o, lpl_o} !== {1'b1, 20'h00022}) begin
            fails++; $display("FAIL order_lpad_ijump: got elp=%b lpl=%h want 1 00022", elp_o, lpl_o); end
    endtask

    task automatic test_lpe_off();
        idle(); commit_valid_i[0] = 1; commit_lpad_i[0] = 1; tick();
        idle(); lpe_i = 0; commit_valid_i[0] = 1; commit_ijump_i[0] = 1;
        commit_label_i[0] = 20'h12345; tick();
        tests++; if ({elp_o, lpl_o} !== {1'b0, 20'h00022}) begin
            fails++; $display("FAIL lpe_off: got elp=%b lpl=%h want 0 00022", elp_o, lpl_o); end
    endtask

    task automatic test_trap_m_mret();
        ijump0(20'h33333);
        idle(); ex_valid_i = 1; trap_to_m_i = 1; tick();
        tests++; if ({elp_o, mpelp_o, spelp_o} !== 3'b010) begin
            fails++; $display("FAIL trap_m: got elp=%b mpelp=%b spelp=%b want 0 1 0", elp_o, mpelp_o, spelp_o); end
        idle(); mret_i = 1; tick();
        tests++; if ({elp_o, mpelp_o} !== 2'b10) begin
            fails++; $display("FAIL mret: got elp=%b mpelp=%b want 1 0", elp_o, mpelp_o); end
    endtask

    task automatic test_trap_s_sret();
        ijump0(20'h44444);
        idle(); ex_valid_i = 1; trap_to_m_i = 0; commit_valid_i[0] = 1; commit_lpad_i[0] = 1; tick();
        tests++; if ({elp_o, mpelp_o, spelp_o} !== 3'b001) begin
            fails++; $display("FAIL trap_s: got elp=%b mpelp=%b spelp=%b want 0 0 1", elp_o, mpelp_o, spelp_o); end
        idle(); sret_i = 1; commit_valid_i[0] = 1; commit_lpad_i[0] = 1; tick();
        tests++; if ({elp_o, spelp_o, lpl_o} !== {2'b10, 20'h44444}) begin
            fails++; $display("FAIL sret: got elp=%b spelp=%b lpl=%h want 1 0 44444", elp_o, spelp_o, lpl_o); end
    endtask

    task automatic test_back_to_back();
        ijump0(20'h55555);
        idle(); ex_valid_i = 1; trap_to_m_i = 1; commit_valid_i[0] = 1; commit_ijump_i[0] = 1;
        commit_label_i[0] = 20'h66666; tick();
        tests++; if ({elp_o, mpelp_o, lpl_o} !== {2'b01, 20'h55555}) begin
            fails++; $display("FAIL b2b_first: got elp=%b mpelp=%b lpl=%h want 0 1 55555", elp_o, mpelp_o, lpl_o); end
        tick();
        tests++; if ({elp_o, mpelp_o} !== 2'b00) begin
            fails++; $display("FAIL b2b_second: got elp=%b mpelp=%b want 0 0", elp_o, mpelp_o); end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 400; n++) begin
            idle();
            lpe_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NCP; i++) begin
                r = $urandom_range(0, 3);
                commit_valid_i[i] = (r != 0);
                commit_ijump_i[i] = (r == 1) || (r == 3 && $urandom_range(0, 1) == 1);
                commit_lpad_i[i]  = (r == 2);
                commit_label_i[i] = 20'($urandom);
            end
            ex_valid_i  = ($urandom_range(0, 7) == 0);
            trap_to_m_i = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 7);
            mret_i = (r == 0);
            sret_i = (r == 1);
            tick();
            tests++; if ({elp_o, lpl_o, mpelp_o, spelp_o} !== {m_elp, m_lpl, m_mpelp, m_spelp}) begin
                fails++;
                $display("FAIL random[%0d]: got %b_%h_%b_%b want %b_%h_%b_%b", n,
                         elp_o, lpl_o, mpelp_o, spelp_o, m_elp, m_lpl, m_mpelp, m_spelp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ijump_lpad();
        test_ordering();
        test_lpe_off();
        test_trap_m_mret();
        test_trap_s_sret();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lpad_tracker.md
# lpad_tracker

Tracks the Zicfilp expected-landing-pad state (ELP), the expected landing-pad label (LPL), and the privilege-banked previous-ELP bits (MPELP/SPELP). It sits in the commit stage and feeds the landing-pad enforcement logic. It arms ELP when an indirect jump commits and disarms it when an LPAD commits. On trap entry it saves ELP into the banked bit for the trap's target privilege. On MRET/SRET it restores ELP from that bit.

## Interface
- CVA6Cfg, default config_pkg::cva6_cfg_empty: core configuration. NrCommitPorts (NCP) is taken from it.
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- lpe_i  in  1  landing-pad enforcement enabled at the current privilege
- commit_valid_i  in  NCP  per-port commit acknowledge
- commit_ijump_i  in  NCP  committed instruction is an indirect JALR/C.JR/C.JALR with rs1 ∉ {x1, x5, x7}
- commit_lpad_i  in  NCP  committed instruction is LPAD
- commit_label_i  in  NCP×20  x7[31:12] sampled at issue of that instruction
- ex_valid_i  in  1  trap taken this cycle
- trap_to_m_i  in  1  trap target is M (1) or S (0)
- mret_i  in  1  MRET commits this cycle
- sret_i  in  1  SRET commits this cycle
- elp_o  out  1  current ELP (1 = LP_EXPECTED), registered
- lpl_o  out  20  current expected label, registered
- mpelp_o  out  1  MPELP, registered
- spelp_o  out  1  SPELP, registered

## Operation
- State registers: elp_q, lpl_q[19:0], mpelp_q, spelp_q. All reset to 0 (NO_LP_EXPECTED, label 0).
- The commit chain walks ports 0..NCP-1 in order. Port i sees the ELP/LPL produced by ports < i. Only ports with commit_valid_i set are evaluated.
  - ijump && lpe_i: ELP := 1, LPL := commit_label_i[i].
  - ijump && !lpe_i: ELP and LPL unchanged.
  - lpad: ELP := 0, LPL unchanged.
  - ijump and lpad both set on one port is illegal (assertion).
- Trap, ex_valid_i=1: highest priority; all commit_* inputs are ignored that cycle.
  - trap_to_m_i=1: MPELP := elp_q.
  - trap_to_m_i=0: SPELP := elp_q.
  - In both cases ELP := 0 and LPL is unchanged.
  - The saved value is the registered ELP, so a landing-pad fault trap saves 1.
- MRET (and no trap): ELP := mpelp_q, MPELP := 0.
- SRET (and no trap): ELP := spelp_q, SPELP := 0.
- Return effects are applied after the commit chain of that cycle, so they override commit effects.
- mret_i and sret_i both set is illegal (assertion).
- LPL is never cleared except by reset.

## Timing
- All outputs are registered. An effect of a commit or trap in cycle N is visible on the outputs in cycle N+1.
- No handshake; single cycle throughput; no stall path.
- Combinational paths: commit inputs → next-state only. There is no input-to-output combinational path.
- rst_i assertion at any time: all four registers become 0 immediately, independent of clk_i. The first update after deassertion occurs on the first clk_i edge with rst_i low.
- Boundary cases with NCP=2:
  - Port 0 ijump, port 1 lpad, same cycle: ELP ends 0, LPL = port-0 label.
  - Port 0 lpad, port 1 ijump: ELP ends 1.
  - Trap coincident with valid commits: commits are discarded.
  - Back-to-back traps: the second trap saves ELP=0.

## Test plan
- Reset: rst_i pulse mid-run with elp_q=1, mpelp_q=1 → all outputs 0 within the same cycle, and they stay 0 after release.
- Port 0 ijump, label 0xABCDE, lpe_i=1 → next cycle elp_o=1, lpl_o=0xABCDE. Port 0 lpad the following cycle → elp_o=0, lpl_o still 0xABCDE.
- Same-cycle ordering (NCP=2):
  - Port 0 ijump label 0x00011, port 1 lpad → elp_o=0, lpl_o=0x00011.
  - Swapped (port 0 lpad, port 1 ijump label 0x00022) → elp_o=1, lpl_o=0x00022.
- lpe_i=0 with port 0 ijump label 0x12345 → elp_o stays 0 and lpl_o is unchanged.
- elp_q=1, ex_valid_i=1, trap_to_m_i=1 → elp_o=0, mpelp_o=1, spelp_o unchanged. Then mret_i → elp_o=1, mpelp_o=0.
- elp_q=1, S-trap with a coincident port-0 lpad commit → spelp_o=1, elp_o=0 (commit ignored). Then sret_i together with a port-0 lpad → elp_o=1 (return overrides commit), spelp_o=0.
